// File: rtl/graphic_pkg.sv
// Shared graphics definitions for the render back end.
// Holds the Color/Weight SRAM word geometry (16 RGB pixels per 384-bit word),
// the RGB pixel type used by the rasterizer's colour packing, the scanout FSM
// state type and a helper that extracts one pixel lane from an SRAM word.
package graphic_pkg;

  localparam int PIX_W        = 24;
  localparam int PIX_PER_WORD = 16;
  localparam int CW_WORD_W    = 384;
  localparam int CW_ADDR_W    = 16;
  localparam int COORD_W      = 12;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } scan_state_t;

  // Lane 0 sits in the LSBs of the word and is the first pixel on screen.
  function automatic rgb_t word_pixel(input logic [CW_WORD_W-1:0] w,
                                      input logic [3:0]           sel);
    return w[sel*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/scanout_word_buf.sv
// Two-entry word FIFO used as the scanout prefetch buffer.
// Ports:
//   clk, srst_n  - clock, asynchronous active-low reset
//   flush        - empties the FIFO (wins over push/pop)
//   push         - write push_data; accepted when not full or when popping
//   push_data    - SRAM word to store
//   pop          - discard the head entry (ignored when empty)
//   head         - current head word
//   occupancy    - number of stored words, 0..2
module scanout_word_buf
  import graphic_pkg::*;
#(
  parameter int WORD_W = CW_WORD_W
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic [1:0]        occupancy
);

  logic [WORD_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    pop_ok  = pop && (count != 2'd0);
    // A full buffer still takes a word when the head leaves in the same cycle.
    push_ok = push && ((count != 2'd2) || pop_ok);
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign head      = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/frame_scanout.sv
// Frame scanout: reads one rendered frame out of the Color/Weight SRAM and
// serialises it into a valid/ready pixel stream with raster coordinates.
// A two-word prefetch buffer covers the one-cycle SRAM read latency so the
// stream runs at one pixel per cycle.
// Ports:
//   clk, srst_n           - clock, asynchronous active-low reset
//   start                 - one-cycle pulse starting a frame (ignored while busy)
//   abort                 - synchronous flush back to idle
//   base_addr             - SRAM word address of pixel (0,0), sampled on start
//   sram_rd_en/sram_addr  - SRAM read request
//   sram_rdata            - SRAM read data, valid the cycle after sram_rd_en
//   pix_data/pix_x/pix_y  - RGB pixel and its column/line
//   pix_valid/pix_ready   - stream handshake
//   pix_last              - final pixel of the frame
//   busy                  - frame in progress
//   done                  - one-cycle pulse after the last pixel is accepted
module frame_scanout
  import graphic_pkg::*;
#(
  parameter int H_RES  = 256,
  parameter int V_RES  = 256,
  parameter int ADDR_W = CW_ADDR_W
) (
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 sram_rd_en,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [CW_WORD_W-1:0] sram_rdata,
  output logic [PIX_W-1:0]     pix_data,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_last,
  output logic                 busy,
  output logic                 done
);

  localparam int FRAME_WORDS = H_RES * V_RES / PIX_PER_WORD;
  localparam int WORD_CNT_W  = $clog2(FRAME_WORDS + 1);

  scan_state_t            state;
  logic [ADDR_W-1:0]      base_q;
  logic [WORD_CNT_W-1:0]  words_issued;
  logic                   inflight;
  logic [3:0]             sel;
  logic [COORD_W-1:0]     x_q;
  logic [COORD_W-1:0]     y_q;

  logic                   buf_flush;
  logic                   buf_pop;
  logic [CW_WORD_W-1:0]   buf_head;
  logic [1:0]             buf_occ;
  logic                   accept;
  logic                   x_end;

  scanout_word_buf #(
    .WORD_W(CW_WORD_W)
  ) u_word_buf (
    .clk       (clk),
    .srst_n    (srst_n),
    .flush     (buf_flush),
    .push      (inflight),
    .push_data (sram_rdata),
    .pop       (buf_pop),
    .head      (buf_head),
    .occupancy (buf_occ)
  );

  always_comb begin
    pix_valid  = (state == ST_RUN) && (buf_occ != 2'd0);
    accept     = pix_valid && pix_ready;
    x_end      = (x_q == COORD_W'(H_RES - 1));
    pix_last   = pix_valid && x_end && (y_q == COORD_W'(V_RES - 1));
    pix_data   = pix_valid ? word_pixel(buf_head, sel) : '0;
    pix_x      = x_q;
    pix_y      = y_q;
    busy       = (state == ST_RUN);
    done       = (state == ST_DONE);
    // Words already buffered plus the one in flight must leave room for the new one.
    sram_rd_en = (state == ST_RUN)
              && (words_issued < WORD_CNT_W'(FRAME_WORDS))
              && ((3'(buf_occ) + 3'(inflight)) < 3'd2);
    sram_addr  = sram_rd_en ? (base_q + ADDR_W'(words_issued)) : '0;
    buf_pop    = accept && (sel == 4'd15);
    // Flushing on abort also drops a word arriving that very cycle.
    buf_flush  = abort || ((state == ST_IDLE) && start);
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      words_issued <= '0;
      inflight     <= 1'b0;
      sel          <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else if (abort) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_RUN;
            base_q       <= base_addr;
            words_issued <= '0;
            inflight     <= 1'b0;
            sel          <= '0;
            x_q          <= '0;
            y_q          <= '0;
          end
        end
        ST_RUN: begin
          inflight <= sram_rd_en;
          if (sram_rd_en) words_issued <= words_issued + WORD_CNT_W'(1);
          if (accept) begin
            sel <= sel + 4'd1;
            if (x_end) begin
              x_q <= '0;
              y_q <= y_q + COORD_W'(1);
            end else begin
              x_q <= x_q + COORD_W'(1);
            end
            if (pix_last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          inflight <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// Testbench for frame_scanout. Four instances cover the default 256x256 frame,
// the minimum 16x1 frame, a 32x1 frame for address wrap and a 64x4 frame for
// backpressure. Each instance has its own SRAM model; expected pixels come from
// a frame-level model: pixel n lives in word base+n/16, lane n%16.
module tb_frame_scanout;

  localparam int NI = 4;
  localparam logic [63:0] HRS = {16'd64, 16'd32, 16'd16, 16'd256};
  localparam logic [63:0] VRS = {16'd4,  16'd1,  16'd1,  16'd256};

  logic                  clk;
  logic                  srst_n;
  logic [NI-1:0]         start;
  logic [NI-1:0]         abort_s;
  logic [15:0]           base_addr;
  logic                  pix_ready;
  logic [NI-1:0]         rd_en;
  logic [NI-1:0][15:0]   addr;
  logic [NI-1:0][23:0]   pd;
  logic [NI-1:0][11:0]   px;
  logic [NI-1:0][11:0]   py;
  logic [NI-1:0]         pv;
  logic [NI-1:0]         plast;
  logic [NI-1:0]         busy;
  logic [NI-1:0]         done_s;

  int checks;
  int errors;
  int mode;

  function automatic logic [23:0] pix_of(input logic [15:0] a, input int k);
    case (mode)
      0:       return 24'(k);
      1:       return {8'h00, a};
      default: return (24'(a) * 24'h009E37) ^ 24'(k * 1103 + 7);
    endcase
  endfunction

  function automatic logic [383:0] make_word(input logic [15:0] a);
    logic [383:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[24*k +: 24] = pix_of(a, k);
    return w;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [383:0] rdata;

    always @(posedge clk) begin
      if (rd_en[g]) rdata <= make_word(addr[g]);
    end

    frame_scanout #(
      .H_RES  (int'(HRS[g*16 +: 16])),
      .V_RES  (int'(VRS[g*16 +: 16])),
      .ADDR_W (16)
    ) u_dut (
      .clk        (clk),
      .srst_n     (srst_n),
      .start      (start[g]),
      .abort      (abort_s[g]),
      .base_addr  (base_addr),
      .sram_rd_en (rd_en[g]),
      .sram_addr  (addr[g]),
      .sram_rdata (rdata),
      .pix_data   (pd[g]),
      .pix_x      (px[g]),
      .pix_y      (py[g]),
      .pix_valid  (pv[g]),
      .pix_ready  (pix_ready),
      .pix_last   (plast[g]),
      .busy       (busy[g]),
      .done       (done_s[g])
    );
  end

  // Runs one frame on instance idx. Negative restart_at/abort_at/rst_at disable
  // those events. chk_lat enables exact cycle checks (needs ready_pct=100).
  task automatic test_frame_stream(input int idx, input int ready_pct,
                                   input int restart_at, input int abort_at,
                                   input int rst_at, input bit chk_lat);
    int h, v, n, fw, acc, issued, cyc, last_acc_cyc;
    bit stalled, restarted, prev_rd;
    logic [23:0] p_d, exp_d;
    logic [11:0] p_x, p_y;
    logic        p_l;
    logic [15:0] base, exp_addr;

    h = int'(HRS[idx*16 +: 16]);
    v = int'(VRS[idx*16 +: 16]);
    n = h * v;
    fw = n / 16;
    base = base_addr;
    acc = 0; issued = 0; last_acc_cyc = -10;
    stalled = 1'b0; restarted = 1'b0; prev_rd = 1'b0;
    p_d = '0; p_x = '0; p_y = '0; p_l = 1'b0;

    @(negedge clk);
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
    cyc = 1;
    while (cyc < 20 * n + 100) begin
      pix_ready = ($urandom_range(99) < ready_pct);

      if (rst_at >= 0 && acc == rst_at) begin
        srst_n = 1'b0;
        #1;
        checks++;
        if (pv[idx] !== 1'b0 || rd_en[idx] !== 1'b0 || busy[idx] !== 1'b0 ||
            done_s[idx] !== 1'b0 || plast[idx] !== 1'b0 || pd[idx] !== 24'h0 ||
            px[idx] !== 12'h0 || py[idx] !== 12'h0 || addr[idx] !== 16'h0) begin
          errors++;
          $display("FAIL reset_mid_frame: got valid=%b rd=%b busy=%b done=%b last=%b data=%h x=%0d y=%0d addr=%h, expected all zero",
                   pv[idx], rd_en[idx], busy[idx], done_s[idx], plast[idx], pd[idx], px[idx], py[idx], addr[idx]);
        end
        @(negedge clk);
        srst_n = 1'b1;
        return;
      end

      if (chk_lat && cyc == 1) begin
        checks++;
        if (rd_en[idx] !== 1'b1 || addr[idx] !== base) begin
          errors++;
          $display("FAIL first_read: got rd=%b addr=%h, expected rd=1 addr=%h", rd_en[idx], addr[idx], base);
        end
      end
      if (chk_lat && cyc <= 3) begin
        checks++;
        if (pv[idx] !== (cyc == 3)) begin
          errors++;
          $display("FAIL first_valid_latency: cycle %0d got valid=%b, expected %b", cyc, pv[idx], cyc == 3);
        end
      end

      if (rd_en[idx]) begin
        exp_addr = base + 16'(issued);
        issued++;
        checks++;
        if (addr[idx] !== exp_addr || issued > fw || issued - acc / 16 > 2) begin
          errors++;
          $display("FAIL read_issue: got addr=%h read#%0d outstanding=%0d, expected addr=%h read<=%0d outstanding<=2",
                   addr[idx], issued, issued - acc / 16, exp_addr, fw);
        end
      end

      if (stalled) begin
        checks++;
        if (pv[idx] !== 1'b1 || pd[idx] !== p_d || px[idx] !== p_x || py[idx] !== p_y || plast[idx] !== p_l) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h x=%0d y=%0d last=%b, expected valid=1 data=%h x=%0d y=%0d last=%b",
                   pv[idx], pd[idx], px[idx], py[idx], plast[idx], p_d, p_x, p_y, p_l);
        end
      end

      if (pv[idx]) begin
        exp_d = pix_of(base + 16'(acc / 16), acc % 16);
        checks++;
        if (acc >= n || pd[idx] !== exp_d || px[idx] !== 12'(acc % h) || py[idx] !== 12'(acc / h) ||
            plast[idx] !== (acc == n - 1) || busy[idx] !== 1'b1) begin
          errors++;
          $display("FAIL pixel #%0d: got data=%h x=%0d y=%0d last=%b busy=%b, expected data=%h x=%0d y=%0d last=%b busy=1",
                   acc, pd[idx], px[idx], py[idx], plast[idx], busy[idx], exp_d, acc % h, acc / h, acc == n - 1);
        end
      end

      if (done_s[idx]) begin
        start[idx] = 1'b0;
        checks++;
        if (acc != n || cyc != last_acc_cyc + 1 || busy[idx] !== 1'b0 || abort_at >= 0 ||
            (chk_lat && cyc != n + 3)) begin
          errors++;
          $display("FAIL done_pulse: got done at cycle %0d after %0d pixels busy=%b, expected cycle %0d after %0d pixels busy=0",
                   cyc, acc, busy[idx], chk_lat ? n + 3 : last_acc_cyc + 1, n);
        end
        @(negedge clk);
        checks++;
        if (done_s[idx] !== 1'b0 || busy[idx] !== 1'b0) begin
          errors++;
          $display("FAIL done_width: got done=%b busy=%b one cycle later, expected 0 0", done_s[idx], busy[idx]);
        end
        return;
      end

      if (abort_at >= 0 && acc >= abort_at && prev_rd) begin
        start[idx] = 1'b0;
        abort_s[idx] = 1'b1;
        @(negedge clk);
        abort_s[idx] = 1'b0;
        checks++;
        if (pv[idx] !== 1'b0 || busy[idx] !== 1'b0 || done_s[idx] !== 1'b0 || rd_en[idx] !== 1'b0) begin
          errors++;
          $display("FAIL abort_idle: got valid=%b busy=%b done=%b rd=%b, expected all 0",
                   pv[idx], busy[idx], done_s[idx], rd_en[idx]);
        end
        repeat (20) begin
          @(negedge clk);
          checks++;
          if (pv[idx] !== 1'b0 || busy[idx] !== 1'b0 || done_s[idx] !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got valid=%b busy=%b done=%b, expected 0 0 0", pv[idx], busy[idx], done_s[idx]);
          end
        end
        return;
      end

      start[idx] = (restart_at >= 0 && acc == restart_at && !restarted);
      if (start[idx]) restarted = 1'b1;

      stalled = pv[idx] && !pix_ready;
      p_d = pd[idx]; p_x = px[idx]; p_y = py[idx]; p_l = plast[idx];
      if (pv[idx] && pix_ready) begin
        acc++;
        last_acc_cyc = cyc;
      end
      prev_rd = rd_en[idx];
      @(negedge clk);
      cyc++;
    end
    start[idx] = 1'b0;
    checks++;
    errors++;
    $display("FAIL timeout: instance %0d got %0d of %0d pixels, expected frame end within budget", idx, acc, n);
  endtask

  task automatic test_reset();
    srst_n = 1'b1;
    #2 srst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (pv[i] !== 1'b0 || rd_en[i] !== 1'b0 || busy[i] !== 1'b0 || done_s[i] !== 1'b0 ||
          plast[i] !== 1'b0 || pd[i] !== 24'h0 || px[i] !== 12'h0 || py[i] !== 12'h0 || addr[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state: instance %0d got valid=%b rd=%b busy=%b done=%b data=%h, expected all zero",
                 i, pv[i], rd_en[i], busy[i], done_s[i], pd[i]);
      end
    end
    srst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== '0 || rd_en !== '0 || pv !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rd=%b valid=%b, expected 0", busy, rd_en, pv);
    end
  endtask

  task automatic test_min_frame();
    mode = 0;
    base_addr = 16'h0010;
    test_frame_stream(1, 100, -1, -1, -1, 1'b1);
    checks++;
    if (busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL min_frame_idle: got busy=%b, expected 0", busy[1]);
    end
  endtask

  task automatic test_addr_wrap();
    mode = 2;
    base_addr = 16'hFFFF;
    test_frame_stream(2, 100, -1, -1, -1, 1'b1);
    checks++;
    if (rd_en[2] !== 1'b0 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: got rd=%b busy=%b, expected 0 0", rd_en[2], busy[2]);
    end
  endtask

  task automatic test_backpressure();
    mode = 2;
    for (int r = 0; r < 3; r++) begin
      base_addr = 16'($urandom);
      test_frame_stream(3, (r == 2) ? 70 : 30, -1, -1, -1, 1'b0);
    end
    checks++;
    if (busy[3] !== 1'b0 || pv[3] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_idle: got busy=%b valid=%b, expected 0 0", busy[3], pv[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    mode = 2;
    base_addr = 16'($urandom);
    test_frame_stream(0, 100, -1, -1, 40, 1'b0);
    base_addr = 16'($urandom);
    test_frame_stream(0, 100, -1, 20, -1, 1'b1);
  endtask

  task automatic test_abort();
    mode = 2;
    base_addr = 16'($urandom);
    test_frame_stream(0, 100, 50, 100, -1, 1'b0);
    @(negedge clk);
    start[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort_s[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || rd_en[0] !== 1'b0 || pv[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: got busy=%b rd=%b valid=%b, expected 0 0 0", busy[0], rd_en[0], pv[0]);
    end
  endtask

  task automatic test_full_frame();
    mode = 1;
    base_addr = 16'h1234;
    test_frame_stream(0, 100, -1, -1, -1, 1'b1);
  endtask

  initial begin
    srst_n = 1'b1;
    start = '0;
    abort_s = '0;
    pix_ready = 1'b0;
    base_addr = '0;
    mode = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_min_frame();
    test_addr_wrap();
    test_backpressure();
    test_reset_mid_frame();
    test_abort();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
